// File: rtl/mmio_console.sv
// Memory-mapped console: TX character FIFO drained at a fixed rate,
// plus optional machine timer with interrupt (MMIO_CONSOLE_TIMER_EN).
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   valid_i, ready_o  bus request / one-cycle registered response
//   addr_i, wdata_i   byte address, write data
//   we_i              byte write enables (0 = read)
//   rdata_o           read data, valid while ready_o=1
//   tx_valid_o        one-cycle pulse per drained character
//   tx_data_o         drained character
//   irq_o             timer interrupt level (0 when timer not built)
module mmio_console #(
   parameter int          ADDR_WIDTH = 32,
   parameter int          WORD_WIDTH = 32,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_3F00,
   parameter int          FIFO_DEPTH = 16,
   parameter int          DRAIN_DIV  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [WORD_WIDTH-1:0] wdata_i,
   input  logic [3:0]            we_i,
   output logic [WORD_WIDTH-1:0] rdata_o,
   output logic                  tx_valid_o,
   output logic [7:0]            tx_data_o,
   output logic                  irq_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int CW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_DIV - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

   localparam logic [2:0] OFF_TX    = 3'd0;
   localparam logic [2:0] OFF_STAT  = 3'd1;
   localparam logic [2:0] OFF_MTIME = 3'd2;
   localparam logic [2:0] OFF_CMP   = 3'd3;
   localparam logic [2:0] OFF_CTRL  = 3'd4;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [LW-1:0]   level;
   logic [CW-1:0]   cnt;
   logic [8:0]      level_ext;

   logic            hit;
   logic            req;
   logic            is_wr;
   logic            tx_wr;
   logic            full;
   logic            empty;
   logic            pop;
   logic            push;
   logic            accept;
   logic [2:0]      off;
   logic [7:0]      tx_char;
   logic [WORD_WIDTH-1:0] rd_val;
   logic            unused;

   assign unused = ^addr_i[1:0];

   // The cycle after an accept (ready_o high) never starts a new access.
   assign hit   = addr_i[ADDR_WIDTH-1:5] == BASE[ADDR_WIDTH-1:5];
   assign req   = valid_i && hit && !ready_o;
   assign off   = addr_i[4:2];
   assign is_wr = |we_i;
   assign tx_wr = req && is_wr && (off == OFF_TX);

   assign empty = level == '0;
   assign full  = level == LVL_FULL;
   assign pop   = (cnt == CNT_LAST) && !empty;

   // A full FIFO still takes a push when the head leaves the same cycle.
   assign push   = tx_wr && (!full || pop);
   assign accept = req && (!tx_wr || push);

   assign level_ext = 9'(level);

   always_comb begin
      tx_char = wdata_i[7:0];
      priority case (1'b1)
         we_i[0]: tx_char = wdata_i[7:0];
         we_i[1]: tx_char = wdata_i[15:8];
         we_i[2]: tx_char = wdata_i[23:16];
         we_i[3]: tx_char = wdata_i[31:24];
         default: tx_char = wdata_i[7:0];
      endcase
   end

`ifdef MMIO_CONSOLE_TIMER_EN
   logic [31:0] mtime;
   logic [31:0] mtimecmp;
   logic        ctrl_ie;
   logic        wr_mtime;
   logic        wr_cmp;
   logic        wr_ctrl;

   function automatic logic [31:0] be_merge(
      input logic [31:0] old,
      input logic [31:0] wd,
      input logic [3:0]  be
   );
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   assign wr_mtime = accept && is_wr && (off == OFF_MTIME);
   assign wr_cmp   = accept && is_wr && (off == OFF_CMP);
   assign wr_ctrl  = accept && is_wr && (off == OFF_CTRL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime    <= '0;
         mtimecmp <= '1;
         ctrl_ie  <= 1'b0;
         irq_o    <= 1'b0;
      end else begin
         if (wr_mtime)
            mtime <= be_merge(mtime, wdata_i, we_i);
         else
            mtime <= mtime + 32'd1;
         if (wr_cmp)
            mtimecmp <= be_merge(mtimecmp, wdata_i, we_i);
         if (wr_ctrl && we_i[0])
            ctrl_ie <= wdata_i[0];
         irq_o <= ctrl_ie && (mtime >= mtimecmp);
      end
   end
`else
   assign irq_o = 1'b0;
`endif

   always_comb begin
      rd_val = '0;
      case (off)
         OFF_STAT:
            rd_val = {16'b0, level_ext[7:0], 6'b0, full, empty};
`ifdef MMIO_CONSOLE_TIMER_EN
         OFF_MTIME: rd_val = mtime;
         OFF_CMP:   rd_val = mtimecmp;
         OFF_CTRL:  rd_val = {31'b0, ctrl_ie};
`endif
         default:   rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_o    <= 1'b0;
         rdata_o    <= '0;
         tx_valid_o <= 1'b0;
         tx_data_o  <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         cnt        <= '0;
      end else begin
         ready_o <= accept;
         if (accept)
            rdata_o <= is_wr ? '0 : rd_val;

         if (cnt == CNT_LAST)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;

         tx_valid_o <= pop;
         if (pop) begin
            tx_data_o <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1'b1;
         end
         if (push)
            wr_ptr <= wr_ptr + 1'b1;

         if (push && !pop)
            level <= level + 1'b1;
         else if (pop && !push)
            level <= level - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= tx_char;
   end

endmodule

// File: tb/tb_mmio_console.sv
// Directed self-checking bench for mmio_console.
// Slow drain divider so FIFO fill/stall timing is reset-aligned.
module tb_mmio_console;

   localparam int          DIV  = 40;
   localparam int          DEP  = 16;
   localparam logic [31:0] BASE = 32'h0000_3F00;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [31:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic [3:0]  we_i = '0;
   logic [31:0] rdata_o;
   logic        tx_valid_o;
   logic [7:0]  tx_data_o;
   logic        irq_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] txq [$];
   int         txc [$];

   logic [3:0] we_tab [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b0110, 4'b1100, 4'b1111, 4'b1010};
   int lane_tab [8] = '{0, 1, 2, 3, 1, 2, 0, 1};

   mmio_console #(
      .ADDR_WIDTH(32),
      .WORD_WIDTH(32),
      .BASE_ADDR(BASE),
      .FIFO_DEPTH(DEP),
      .DRAIN_DIV(DIV)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .addr_i(addr_i),
      .wdata_i(wdata_i),
      .we_i(we_i),
      .rdata_o(rdata_o),
      .tx_valid_o(tx_valid_o),
      .tx_data_o(tx_data_o),
      .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      if (tx_valid_o) begin
         txq.push_back(tx_data_o);
         txc.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic do_reset();
      @(negedge clk);
      valid_i = 1'b0;
      we_i = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      txq.delete();
      txc.delete();
      rst_n = 1'b1;
   endtask

   task automatic bus(input logic [31:0] a, input logic [3:0] we,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output int lat, output int acc);
      addr_i = a;
      we_i = we;
      wdata_i = wd;
      valid_i = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!ready_o && lat < 200);
      acc = cyc;
      rd = rdata_o;
      if (!ready_o) begin
         checks++;
         errors++;
         $display("FAIL bus_timeout addr=%h got ready=0 want 1", a);
      end
      valid_i = 1'b0;
      we_i = '0;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      int lat, acc;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ready_o, rdata_o, tx_valid_o, tx_data_o, irq_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %b %h %b %h %b want all 0",
                  ready_o, rdata_o, tx_valid_o, tx_data_o, irq_o);
      end
      rst_n = 1'b1;
      bus(BASE + 32'h4, 4'b0000, 32'h0, rd, lat, acc);
      checks++;
      if (rd !== 32'h0000_0001) begin
         errors++;
         $display("FAIL reset_status got %h want 00000001", rd);
      end
      checks++;
      if (lat !== 1) begin
         errors++;
         $display("FAIL first_latency got %0d want 1", lat);
      end
`ifdef MMIO_CONSOLE_TIMER_EN
      bus(BASE + 32'hC, 4'b0000, 32'h0, rd, lat, acc);
      checks++;
      if (rd !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL reset_mtimecmp got %h want ffffffff", rd);
      end
      bus(BASE + 32'h10, 4'b0000, 32'h0, rd, lat, acc);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL reset_ctrl got %h want 0", rd);
      end
`endif
   endtask

   task automatic test_ready_pulse();
      logic [5:0] seen;
      do_reset();
      addr_i = BASE + 32'h4;
      we_i = '0;
      valid_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         seen[i] = ready_o;
      end
      valid_i = 1'b0;
      checks++;
      if (seen !== 6'b010101) begin
         errors++;
         $display("FAIL ready_pulse got %b want 010101", seen);
      end
   endtask

   task automatic test_tx_order();
      logic [31:0] rd;
      int lat, acc;
      do_reset();
      bus(BASE, 4'b1000, 32'h4112_3456, rd, lat, acc);
      bus(BASE, 4'b0001, 32'h9988_7742, rd, lat, acc);
      for (int k = 0; k < 3 * DIV && txq.size() < 2; k++)
         @(negedge clk);
      checks++;
      if (txq.size() < 2) begin
         errors++;
         $display("FAIL tx_count got %0d want 2", txq.size());
      end else begin
         checks += 2;
         if (txq[0] !== 8'h41) begin
            errors++;
            $display("FAIL tx_first got %h want 41", txq[0]);
         end
         if (txq[1] !== 8'h42) begin
            errors++;
            $display("FAIL tx_second got %h want 42", txq[1]);
         end
         checks++;
         if (txc[1] - txc[0] !== DIV) begin
            errors++;
            $display("FAIL tx_spacing got %0d want %0d",
                     txc[1] - txc[0], DIV);
         end
      end
   endtask

   task automatic test_status();
      logic [31:0] rd;
      int lat, acc;
      do_reset();
      bus(BASE, 4'b0001, 32'h61, rd, lat, acc);
      bus(BASE, 4'b0001, 32'h62, rd, lat, acc);
      bus(BASE, 4'b0001, 32'h63, rd, lat, acc);
      bus(BASE + 32'h4, 4'b0000, 32'h0, rd, lat, acc);
      checks++;
      if (rd !== 32'h0000_0300) begin
         errors++;
         $display("FAIL status_three got %h want 00000300", rd);
      end
      bus(BASE + 32'h14, 4'b1111, 32'hFFFF_FFFF, rd, lat, acc);
      bus(BASE + 32'h14, 4'b0000, 32'h0, rd, lat, acc);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL unmapped_read got %h want 0", rd);
      end
      for (int k = 0; k < 4 * DIV && txq.size() < 3; k++)
         @(negedge clk);
      bus(BASE + 32'h4, 4'b0000, 32'h0, rd, lat, acc);
      checks++;
      if (rd !== 32'h0000_0001) begin
         errors++;
         $display("FAIL status_drained got %h want 00000001", rd);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, wd;
      logic [7:0]  exp;
      int lat, acc, bad;
      int lat_last, acc_last;
      do_reset();
      bad = 0;
      for (int i = 0; i < 17; i++) begin
         wd = 32'hA5A5_A5A5;
         wd[8*lane_tab[i%8] +: 8] = 8'h30 + 8'(i);
         bus(BASE, we_tab[i%8], wd, rd, lat, acc);
         if (i < 16 && lat != ((i == 0) ? 1 : 2)) bad++;
         lat_last = lat;
         acc_last = acc;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL fill_nostall got %0d stalls want 0", bad);
      end
      checks++;
      if (lat_last !== 9) begin
         errors++;
         $display("FAIL stall_latency got %0d want 9", lat_last);
      end
      checks++;
      if (txq.size() == 0 || acc_last !== txc[0]) begin
         errors++;
         $display("FAIL stall_release got %0d want first pop cycle",
                  acc_last);
      end
      for (int k = 0; k < 18 * DIV && txq.size() < 17; k++)
         @(negedge clk);
      checks++;
      if (txq.size() !== 17) begin
         errors++;
         $display("FAIL drain_count got %0d want 17", txq.size());
      end else begin
         bad = 0;
         for (int i = 0; i < 17; i++) begin
            exp = 8'h30 + 8'(i);
            if (txq[i] !== exp) bad++;
         end
         checks++;
         if (bad !== 0) begin
            errors++;
            $display("FAIL drain_order got %0d wrong chars want 0", bad);
         end
      end
   endtask

   task automatic test_window();
      logic [31:0] rd;
      int lat, acc, seen;
      do_reset();
      addr_i = 32'h0000_3E00;
      we_i = 4'b0001;
      wdata_i = 32'h55;
      valid_i = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ready_o) seen++;
      end
      valid_i = 1'b0;
      we_i = '0;
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL out_of_window got %0d ready want 0", seen);
      end
      bus(BASE + 32'h4, 4'b0000, 32'h0, rd, lat, acc);
      checks++;
      if (rd !== 32'h0000_0001) begin
         errors++;
         $display("FAIL window_nopush got %h want 00000001", rd);
      end
   endtask

   task automatic test_reset_stall();
      logic [31:0] rd;
      int lat, acc;
      do_reset();
      for (int i = 0; i < 16; i++)
         bus(BASE, 4'b0001, 32'h70 + 32'(i), rd, lat, acc);
      addr_i = BASE;
      we_i = 4'b0001;
      wdata_i = 32'h7F;
      valid_i = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (ready_o !== 1'b0) begin
         errors++;
         $display("FAIL stall_hold got ready=%b want 0", ready_o);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ready_o, rdata_o, tx_valid_o, tx_data_o, irq_o} !== '0) begin
         errors++;
         $display("FAIL stall_reset_out got %b %h %b %h %b want all 0",
                  ready_o, rdata_o, tx_valid_o, tx_data_o, irq_o);
      end
      @(negedge clk);
      valid_i = 1'b0;
      we_i = '0;
      txq.delete();
      txc.delete();
      rst_n = 1'b1;
      bus(BASE + 32'h4, 4'b0000, 32'h0, rd, lat, acc);
      checks++;
      if (rd !== 32'h0000_0001) begin
         errors++;
         $display("FAIL stall_reset_empty got %h want 00000001", rd);
      end
      repeat (2 * DIV) @(negedge clk);
      checks++;
      if (txq.size() !== 0) begin
         errors++;
         $display("FAIL stale_tx got %0d chars want 0", txq.size());
      end
   endtask

`ifdef MMIO_CONSOLE_TIMER_EN
   task automatic test_timer();
      logic [31:0] rd;
      int lat, acc, acc0, rise;
      do_reset();
      bus(BASE + 32'h10, 4'b1111, 32'h1, rd, lat, acc);
      bus(BASE + 32'hC, 4'b1111, 32'h20, rd, lat, acc);
      bus(BASE + 32'h8, 4'b1111, 32'h10, rd, lat, acc0);
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL irq_early got %b want 0", irq_o);
      end
      bus(BASE + 32'h8, 4'b0000, 32'h0, rd, lat, acc);
      checks++;
      if (rd !== 32'h11) begin
         errors++;
         $display("FAIL mtime_read got %h want 00000011", rd);
      end
      rise = -1;
      for (int k = 0; k < 100 && rise < 0; k++) begin
         if (irq_o) rise = cyc;
         else @(negedge clk);
      end
      checks++;
      if (rise - acc0 !== 17) begin
         errors++;
         $display("FAIL irq_rise got %0d want 17", rise - acc0);
      end
      bus(BASE + 32'h10, 4'b0000, 32'h0, rd, lat, acc);
      checks++;
      if (rd !== 32'h1) begin
         errors++;
         $display("FAIL ctrl_read got %h want 1", rd);
      end
      bus(BASE + 32'hC, 4'b1111, 32'hFFFF_FFFF, rd, lat, acc);
      repeat (2) @(negedge clk);
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL irq_clear got %b want 0", irq_o);
      end
      bus(BASE + 32'hC, 4'b0001, 32'h1234_5655, rd, lat, acc);
      bus(BASE + 32'hC, 4'b0000, 32'h0, rd, lat, acc);
      checks++;
      if (rd !== 32'hFFFF_FF55) begin
         errors++;
         $display("FAIL cmp_byte_en got %h want ffffff55", rd);
      end
      bus(BASE + 32'h8, 4'b1111, 32'hFFFF_FFFF, rd, lat, acc);
      bus(BASE + 32'h8, 4'b0000, 32'h0, rd, lat, acc);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL mtime_wrap got %h want 0", rd);
      end
   endtask
`else
   task automatic test_timer();
      logic [31:0] rd;
      int lat, acc;
      do_reset();
      bus(BASE + 32'h10, 4'b1111, 32'h1, rd, lat, acc);
      bus(BASE + 32'hC, 4'b1111, 32'h0, rd, lat, acc);
      bus(BASE + 32'h8, 4'b1111, 32'h10, rd, lat, acc);
      bus(BASE + 32'h8, 4'b0000, 32'h0, rd, lat, acc);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL notimer_mtime got %h want 0", rd);
      end
      bus(BASE + 32'hC, 4'b0000, 32'h0, rd, lat, acc);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL notimer_cmp got %h want 0", rd);
      end
      bus(BASE + 32'h10, 4'b0000, 32'h0, rd, lat, acc);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL notimer_ctrl got %h want 0", rd);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL notimer_irq got %b want 0", irq_o);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_ready_pulse();
      test_tx_order();
      test_status();
      test_back_to_back();
      test_window();
      test_reset_stall();
      test_timer();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
